// File: rtl/pipe_mem_wb_fifo.sv
// Elastic MEM/WB writeback FIFO: valid/ready on both sides, per-thread flush
// that turns held entries into bubbles, and a two-port forwarding lookup.
module pipe_mem_wb_fifo #(
    parameter int  DATAPATH_WIDTH     = 64,
    parameter int  REGFILE_ADDR_WIDTH = 5,
    parameter int  THREAD_BITS        = 2,
    parameter int  DEPTH              = 2,
    localparam int NUM_THREADS        = 2 ** THREAD_BITS,
    localparam int PTR_W              = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATAPATH_WIDTH-1:0]     accum_in,
    input  logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_in,
    input  logic                          WR_en_in,
    input  logic                          mem_reg_sel_in,
    input  logic [THREAD_BITS-1:0]        thread_id_in,
    input  logic [NUM_THREADS-1:0]        flush_mask,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATAPATH_WIDTH-1:0]     accum_out,
    output logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_out,
    output logic                          WR_en_out,
    output logic                          mem_reg_sel_out,
    output logic [THREAD_BITS-1:0]        thread_id_out,
    input  logic [THREAD_BITS-1:0]        rd_thread,
    input  logic [REGFILE_ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [REGFILE_ADDR_WIDTH-1:0] rd_addr_b,
    output logic                          hit_a,
    output logic                          hit_b,
    output logic [DATAPATH_WIDTH-1:0]     fwd_data_a,
    output logic [DATAPATH_WIDTH-1:0]     fwd_data_b,
    output logic [PTR_W:0]                count
);

    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [DATAPATH_WIDTH-1:0]     accum_q [DEPTH];
    logic [DATAPATH_WIDTH-1:0]     accum_d [DEPTH];
    logic [REGFILE_ADDR_WIDTH-1:0] addr_q  [DEPTH];
    logic [REGFILE_ADDR_WIDTH-1:0] addr_d  [DEPTH];
    logic [THREAD_BITS-1:0]        tid_q   [DEPTH];
    logic [THREAD_BITS-1:0]        tid_d   [DEPTH];
    logic [DEPTH-1:0]              wen_q, wen_d;
    logic [DEPTH-1:0]              sel_q, sel_d;
    logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]                count_q, count_d;
    logic [DEPTH-1:0]              occ;
    logic [PTR_W-1:0]              idx;
    logic                          push, pop;

    assign in_ready  = (count_q != FULL) && !reset;
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    assign accum_out       = out_valid ? accum_q[rd_ptr_q] : '0;
    assign WR_addr_out     = out_valid ? addr_q[rd_ptr_q]  : '0;
    assign WR_en_out       = out_valid ? wen_q[rd_ptr_q]   : 1'b0;
    assign mem_reg_sel_out = out_valid ? sel_q[rd_ptr_q]   : 1'b0;
    assign thread_id_out   = out_valid ? tid_q[rd_ptr_q]   : '0;

    // A slot is occupied when its distance from the head is below the count.
    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ[i] = {1'b0, PTR_W'(i) - rd_ptr_q} < count_q;
        end
    end

    always_comb begin
        accum_d = accum_q;
        addr_d  = addr_q;
        tid_d   = tid_q;
        wen_d   = wen_q;
        sel_d   = sel_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[i] && flush_mask[tid_q[i]]) wen_d[i] = 1'b0;
        end
        // The push slot is never occupied, so it cannot collide with the flush above.
        if (push) begin
            accum_d[wr_ptr_q] = accum_in;
            addr_d[wr_ptr_q]  = WR_addr_in;
            tid_d[wr_ptr_q]   = thread_id_in;
            wen_d[wr_ptr_q]   = WR_en_in && !flush_mask[thread_id_in];
            sel_d[wr_ptr_q]   = mem_reg_sel_in;
        end
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + (PTR_W + 1)'(1);
        else if (pop && !push) count_d = count_q - (PTR_W + 1)'(1);
    end

    // Walk oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hit_a      = 1'b0;
        hit_b      = 1'b0;
        fwd_data_a = '0;
        fwd_data_b = '0;
        idx        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if (((PTR_W + 1)'(k) < count_q) && wen_q[idx] && (tid_q[idx] == rd_thread)) begin
                if (addr_q[idx] == rd_addr_a) begin
                    hit_a      = 1'b1;
                    fwd_data_a = accum_q[idx];
                end
                if (addr_q[idx] == rd_addr_b) begin
                    hit_b      = 1'b1;
                    fwd_data_b = accum_q[idx];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                accum_q[i] <= '0;
                addr_q[i]  <= '0;
                tid_q[i]   <= '0;
            end
            wen_q    <= '0;
            sel_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            accum_q  <= accum_d;
            addr_q   <= addr_d;
            tid_q    <= tid_d;
            wen_q    <= wen_d;
            sel_q    <= sel_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_pipe_mem_wb_fifo.sv
// Scenario bench for pipe_mem_wb_fifo: queue scoreboard of expected entries
// plus fixed expectations for occupancy, lookup, flush and reset behaviour.
module tb_pipe_mem_wb_fifo;

    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int TB    = 2;
    localparam int DEPTH = 2;

    typedef struct {
        logic [DW-1:0] accum;
        logic [AW-1:0] addr;
        logic          wen;
        logic          sel;
        logic [TB-1:0] tid;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] accum_in = '0;
    logic [AW-1:0] WR_addr_in = '0;
    logic          WR_en_in = 1'b0;
    logic          mem_reg_sel_in = 1'b0;
    logic [TB-1:0] thread_id_in = '0;
    logic [3:0]    flush_mask = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] accum_out;
    logic [AW-1:0] WR_addr_out;
    logic          WR_en_out;
    logic          mem_reg_sel_out;
    logic [TB-1:0] thread_id_out;
    logic [TB-1:0] rd_thread = '0;
    logic [AW-1:0] rd_addr_a = '0;
    logic [AW-1:0] rd_addr_b = '0;
    logic          hit_a, hit_b;
    logic [DW-1:0] fwd_data_a, fwd_data_b;
    logic [1:0]    count;

    ent_t sb[$];
    int   errs = 0;
    int   checks = 0;

    pipe_mem_wb_fifo #(
        .DATAPATH_WIDTH(DW), .REGFILE_ADDR_WIDTH(AW), .THREAD_BITS(TB), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .accum_in(accum_in), .WR_addr_in(WR_addr_in), .WR_en_in(WR_en_in),
        .mem_reg_sel_in(mem_reg_sel_in), .thread_id_in(thread_id_in),
        .flush_mask(flush_mask), .out_valid(out_valid), .out_ready(out_ready),
        .accum_out(accum_out), .WR_addr_out(WR_addr_out), .WR_en_out(WR_en_out),
        .mem_reg_sel_out(mem_reg_sel_out), .thread_id_out(thread_id_out),
        .rd_thread(rd_thread), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .hit_a(hit_a), .hit_b(hit_b), .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
        .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Advance one edge, updating the scoreboard the way the stage should.
    task automatic tick();
        bit   do_push, do_pop;
        ent_t e;
        do_push = in_valid && (sb.size() < DEPTH) && !reset;
        do_pop  = out_ready && (sb.size() != 0) && !reset;
        if (do_pop) void'(sb.pop_front());
        for (int i = 0; i < sb.size(); i++) begin
            if (flush_mask[sb[i].tid]) sb[i].wen = 1'b0;
        end
        if (do_push) begin
            e.accum = accum_in;
            e.addr  = WR_addr_in;
            e.wen   = WR_en_in && !flush_mask[thread_id_in];
            e.sel   = mem_reg_sel_in;
            e.tid   = thread_id_in;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [DW-1:0] a, input logic [AW-1:0] r,
                         input logic [TB-1:0] t, input logic s);
        in_valid       = 1'b1;
        accum_in       = a;
        WR_addr_in     = r;
        thread_id_in   = t;
        mem_reg_sel_in = s;
        WR_en_in       = 1'b1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) tick();
        out_ready = 1'b0;
        checks++; if (count !== 2'd0) begin errs++; $display("FAIL drain_count: got %0d want 0", count); end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin errs++; $display("FAIL rst_state: got valid=%b count=%0d want 0/0", out_valid, count); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        offer(64'h11, 5'd3, 2'd1, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || WR_addr_out !== 5'd3 || count !== 2'd1) begin
            errs++; $display("FAIL basic_head: got valid=%b addr=%0d count=%0d want 1/3/1", out_valid, WR_addr_out, count); end
        checks++; if (accum_out !== sb[0].accum || mem_reg_sel_out !== 1'b1 || thread_id_out !== 2'd1) begin
            errs++; $display("FAIL basic_fields: got accum=%0h sel=%b tid=%0d want %0h/1/1", accum_out, mem_reg_sel_out, thread_id_out, sb[0].accum); end
        rd_thread = 2'd1; rd_addr_a = 5'd3; rd_addr_b = 5'd4;
        #1;
        checks++; if (hit_a !== 1'b1 || fwd_data_a !== 64'h11) begin
            errs++; $display("FAIL basic_fwd_a: got hit=%b data=%0h want 1/11", hit_a, fwd_data_a); end
        checks++; if (hit_b !== 1'b0 || fwd_data_b !== 64'h0) begin
            errs++; $display("FAIL basic_fwd_b: got hit=%b data=%0h want 0/0", hit_b, fwd_data_b); end
        drain();
    endtask

    task automatic test_full();
        offer(64'hA1, 5'd1, 2'd0, 1'b0); tick();
        offer(64'hB2, 5'd2, 2'd0, 1'b0); tick();
        checks++; if (in_ready !== 1'b0 || count !== 2'd2) begin
            errs++; $display("FAIL full_ready: got ready=%b count=%0d want 0/2", in_ready, count); end
        offer(64'hC3, 5'd3, 2'd0, 1'b0); tick();
        checks++; if (count !== 2'd2 || accum_out !== 64'hA1) begin
            errs++; $display("FAIL full_refuse: got count=%0d head=%0h want 2/a1", count, accum_out); end
        out_ready = 1'b1;
        checks++; if (accum_out !== sb[0].accum) begin errs++; $display("FAIL full_pop_head: got %0h want %0h", accum_out, sb[0].accum); end
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || count !== 2'd1 || accum_out !== 64'hB2) begin
            errs++; $display("FAIL full_after_pop: got ready=%b count=%0d head=%0h want 1/1/b2", in_ready, count, accum_out); end
        drain();
    endtask

    task automatic test_youngest();
        offer(64'hAA, 5'd5, 2'd0, 1'b0); tick();
        offer(64'hBB, 5'd5, 2'd0, 1'b0); tick();
        in_valid = 1'b0;
        rd_thread = 2'd0; rd_addr_a = 5'd5; rd_addr_b = 5'd6;
        #1;
        checks++; if (hit_a !== 1'b1 || fwd_data_a !== 64'hBB) begin
            errs++; $display("FAIL young_fwd: got hit=%b data=%0h want 1/bb", hit_a, fwd_data_a); end
        rd_thread = 2'd2;
        #1;
        checks++; if (hit_a !== 1'b0 || fwd_data_a !== 64'h0) begin
            errs++; $display("FAIL young_other_thread: got hit=%b data=%0h want 0/0", hit_a, fwd_data_a); end
        drain();
    endtask

    task automatic test_flush();
        offer(64'h70, 5'd7, 2'd0, 1'b0); tick();
        offer(64'h80, 5'd8, 2'd2, 1'b0); tick();
        in_valid = 1'b0;
        flush_mask = 4'b0100;
        tick();
        flush_mask = 4'b0000;
        checks++; if (count !== 2'd2) begin errs++; $display("FAIL flush_count: got %0d want 2", count); end
        rd_thread = 2'd2; rd_addr_a = 5'd8;
        #1;
        checks++; if (hit_a !== 1'b0) begin errs++; $display("FAIL flush_lookup_t2: got %b want 0", hit_a); end
        rd_thread = 2'd0; rd_addr_b = 5'd7;
        #1;
        checks++; if (hit_b !== 1'b1 || fwd_data_b !== 64'h70) begin
            errs++; $display("FAIL flush_lookup_t0: got hit=%b data=%0h want 1/70", hit_b, fwd_data_b); end
        out_ready = 1'b1;
        checks++; if (WR_en_out !== 1'b1 || thread_id_out !== 2'd0) begin
            errs++; $display("FAIL flush_keep_t0: got wen=%b tid=%0d want 1/0", WR_en_out, thread_id_out); end
        tick();
        checks++; if (WR_en_out !== 1'b0 || thread_id_out !== 2'd2 || WR_en_out !== sb[0].wen) begin
            errs++; $display("FAIL flush_bubble_t2: got wen=%b tid=%0d want 0/2", WR_en_out, thread_id_out); end
        tick();
        out_ready = 1'b0;
        // Pop during flush keeps pre-flush WR_en; flushed push is stored as a bubble.
        offer(64'h90, 5'd9, 2'd2, 1'b0); tick();
        offer(64'h91, 5'd10, 2'd2, 1'b0);
        out_ready = 1'b1; flush_mask = 4'b0100;
        checks++; if (WR_en_out !== 1'b1 || accum_out !== 64'h90) begin
            errs++; $display("FAIL flush_pop_same_cycle: got wen=%b accum=%0h want 1/90", WR_en_out, accum_out); end
        tick();
        flush_mask = 4'b0000; in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (WR_en_out !== 1'b0 || accum_out !== 64'h91 || count !== 2'd1) begin
            errs++; $display("FAIL flush_push_same_cycle: got wen=%b accum=%0h count=%0d want 0/91/1", WR_en_out, accum_out, count); end
        drain();
    endtask

    task automatic test_back_to_back();
        offer(64'h1000, 5'd0, 2'd3, 1'b1); tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(64'h2000 + 64'(i), 5'(i + 1), 2'(i), i[0]);
            checks++; if (sb.size() != 1 || accum_out !== sb[0].accum || WR_addr_out !== sb[0].addr || count !== 2'd1) begin
                errs++; $display("FAIL stream_%0d: got accum=%0h addr=%0d count=%0d want %0h/%0d/1",
                                 i, accum_out, WR_addr_out, count, sb[0].accum, sb[0].addr); end
            tick();
        end
        in_valid = 1'b0;
        checks++; if (accum_out !== 64'h2009) begin errs++; $display("FAIL stream_last: got %0h want 2009", accum_out); end
        drain();
    endtask

    task automatic test_async_reset();
        offer(64'h55, 5'd12, 2'd1, 1'b1); tick();
        offer(64'h66, 5'd13, 2'd1, 1'b1); tick();
        in_valid = 1'b0;
        rd_thread = 2'd1; rd_addr_a = 5'd12;
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        checks++; if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b0) begin
            errs++; $display("FAIL areset_ctrl: got valid=%b count=%0d ready=%b want 0/0/0", out_valid, count, in_ready); end
        checks++; if (accum_out !== 64'h0 || WR_addr_out !== 5'd0 || WR_en_out !== 1'b0 ||
                      mem_reg_sel_out !== 1'b0 || thread_id_out !== 2'd0 || hit_a !== 1'b0) begin
            errs++; $display("FAIL areset_data: got accum=%0h addr=%0d wen=%b sel=%b tid=%0d hit=%b want all 0",
                             accum_out, WR_addr_out, WR_en_out, mem_reg_sel_out, thread_id_out, hit_a); end
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL areset_held_ready: got %b want 0", in_ready); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errs++; $display("FAIL areset_release: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin
            errs++; $display("FAIL areset_no_output: got valid=%b count=%0d want 0/0", out_valid, count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_youngest();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
